// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_pkg
// Description : Shared constants, state encoding and helpers for the generic
//               pipeline stage register.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_stage_reg_pkg;

  // Default payload layout: pc[95:64], npc[63:32], instr[31:0]
  localparam int PIPE_DATA_W = 96;
  localparam int PIPE_CNT_W  = 16;

  // Canonical NOP (addi x0, x0, 0) placed in the instr field of a bubble
  localparam logic [31:0] INSTRUCTION_NOP = 32'h0000_0013;
  localparam logic [95:0] PIPE_BUBBLE     = {32'd0, 32'd0, INSTRUCTION_NOP};

  // Stage occupancy states for the skid-buffered variant
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FULL    = 2'd1,
    ST_SKIDDED = 2'd2
  } stage_state_e;

  // Number of held entries implied by a skid-variant state
  function automatic logic [1:0] state_occupancy(input stage_state_e s);
    case (s)
      ST_FULL:    return 2'd1;
      ST_SKIDDED: return 2'd2;
      default:    return 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : WIDTH-bit incrementer that sticks at all-ones, with a
//               synchronous active-low clear.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clock_i,
  input  logic             clear_n_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next value: step by one unless already at the ceiling
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Counter register with synchronous clear
  always_ff @(posedge clock_i) begin
    if (!clear_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised valid/ready pipeline stage register with an
//               optional one-entry skid buffer, synchronous flush with bubble
//               insertion, and saturating stall/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W = PIPE_DATA_W,
  parameter logic [DATA_W-1:0] BUBBLE = DATA_W'(PIPE_BUBBLE),
  parameter bit                SKID   = 1'b1,
  parameter int                CNT_W  = PIPE_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_ready_raw;
  logic              w_valid;
  logic [DATA_W-1:0] w_main;

  // Nothing enters during a flush; out_valid is deliberately left unmasked
  assign in_ready   = w_ready_raw && !flush;
  assign out_valid  = w_valid;
  assign out_data   = w_valid ? w_main : BUBBLE;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = w_valid && out_ready;

  if (SKID) begin : g_skid
    stage_state_e      state_q;
    logic              ready_q;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    // Two-entry FSM; ready_q is precomputed as "next state is not SKIDDED"
    always_ff @(posedge clock) begin
      if (!reset || flush) begin
        state_q <= ST_EMPTY;
        ready_q <= 1'b1;
        main_q  <= BUBBLE;
        skid_q  <= BUBBLE;
      end else begin
        unique case (state_q)
          ST_EMPTY: begin
            if (w_in_xfer) begin
              main_q  <= in_data;
              state_q <= ST_FULL;
            end
          end
          ST_FULL: begin
            if (w_in_xfer && w_out_xfer) begin
              main_q <= in_data;
            end else if (w_out_xfer) begin
              state_q <= ST_EMPTY;
            end else if (w_in_xfer) begin
              skid_q  <= in_data;
              state_q <= ST_SKIDDED;
              ready_q <= 1'b0;
            end
          end
          ST_SKIDDED: begin
            if (w_out_xfer) begin
              main_q  <= skid_q;
              state_q <= ST_FULL;
              ready_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
          end
        endcase
      end
    end

    assign w_ready_raw = ready_q;
    assign w_valid     = (state_q != ST_EMPTY);
    assign w_main      = main_q;
    assign occupancy   = state_occupancy(state_q);
  end else begin : g_noskid
    logic              valid_q;
    logic [DATA_W-1:0] main_q;

    // Single entry: load on accept, drain when consumed without refill
    always_ff @(posedge clock) begin
      if (!reset || flush) begin
        valid_q <= 1'b0;
        main_q  <= BUBBLE;
      end else if (w_in_xfer) begin
        valid_q <= 1'b1;
        main_q  <= in_data;
      end else if (w_out_xfer) begin
        valid_q <= 1'b0;
      end
    end

    assign w_ready_raw = !valid_q || out_ready;
    assign w_valid     = valid_q;
    assign w_main      = main_q;
    assign occupancy   = {1'b0, valid_q};
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_stall_cnt (
    .clock_i  (clock),
    .clear_n_i(reset),
    .inc_i    (w_valid && !out_ready),
    .count_o  (stall_cnt)
  );

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_flush_cnt (
    .clock_i  (clock),
    .clear_n_i(reset),
    .inc_i    (flush && (occupancy != 2'd0)),
    .count_o  (flush_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg; a SKID=0/CNT_W=4 and
//               a SKID=1/CNT_W=16 instance share one stimulus stream and are
//               each compared against a queue-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam logic [95:0] BUB = {64'd0, 32'h0000_0013};
  localparam logic [95:0] A   = 96'hAAAA_0001_AAAA_0002_AAAA_0003;
  localparam logic [95:0] B   = 96'hBBBB_0001_BBBB_0002_BBBB_0003;
  localparam logic [95:0] C   = 96'hCCCC_0001_CCCC_0002_CCCC_0003;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [95:0] in_data;

  logic        ir0, ov0, ir1, ov1;
  logic [95:0] od0, od1;
  logic [1:0]  oc0, oc1;
  logic [3:0]  st0, fc0;
  logic [15:0] st1, fc1;
  logic [31:0] instr_field;

  pipe_stage_reg #(.DATA_W(96), .SKID(1'b0), .CNT_W(4)) dut0 (
    .clock(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .occupancy(oc0), .stall_cnt(st0), .flush_cnt(fc0)
  );

  pipe_stage_reg #(.DATA_W(96), .SKID(1'b1), .CNT_W(16)) dut1 (
    .clock(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(oc1), .stall_cnt(st1), .flush_cnt(fc1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: index 0 = SKID0, 1 = SKID1 ----------------
  logic [95:0] md [2][2];      // held payloads, oldest at [0]
  int          mn   [2];       // number held
  int          mst  [2];
  int          mfl  [2];
  int          cmax [2] = '{15, 65535};
  bit          chk  = 1'b0;
  logic        ir_m, ov_m;

  function automatic logic m_ir(input int k);
    if (k == 0) return (mn[0] == 0 || out_ready) && !flush;
    return (mn[1] < 2) && !flush;
  endfunction

  // Advance the model on each rising edge using the inputs present at that edge
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ir_m = m_ir(k);
      ov_m = (mn[k] > 0);
      if (!reset) begin
        mn[k] = 0; mst[k] = 0; mfl[k] = 0;
      end else begin
        if (ov_m && !out_ready && mst[k] < cmax[k]) mst[k]++;
        if (flush) begin
          if (mn[k] != 0 && mfl[k] < cmax[k]) mfl[k]++;
          mn[k] = 0;
        end else begin
          if (ov_m && out_ready) begin
            md[k][0] = md[k][1];
            mn[k]--;
          end
          if (in_valid && ir_m) begin
            md[k][mn[k]] = in_data;
            mn[k]++;
          end
        end
      end
    end
    if (!reset) chk = 1'b1;
  end

  // Compare both instances against the model on every falling edge
  always @(negedge clk) begin
    if (chk) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("dut%0d in_ready", k),  96'(k == 0 ? ir0 : ir1), 96'(m_ir(k)));
        check($sformatf("dut%0d out_valid", k), 96'(k == 0 ? ov0 : ov1), 96'(mn[k] > 0));
        check($sformatf("dut%0d out_data", k),  (k == 0 ? od0 : od1), (mn[k] > 0) ? md[k][0] : BUB);
        check($sformatf("dut%0d occupancy", k), 96'(k == 0 ? oc0 : oc1), 96'(mn[k]));
        check($sformatf("dut%0d stall_cnt", k), (k == 0 ? {92'd0, st0} : {80'd0, st1}), 96'(mst[k]));
        check($sformatf("dut%0d flush_cnt", k), (k == 0 ? {92'd0, fc0} : {80'd0, fc1}), 96'(mfl[k]));
      end
    end
  end

  task automatic drive(input logic r, input logic f, input logic iv, input logic [95:0] d, input logic ordy);
    reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus with hand-computed anchor checks ----------------
  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    check("rst out_valid", 96'(ov1), 96'd0);
    check("rst out_data",  od1, BUB);
    check("rst occupancy", 96'(oc1), 96'd0);
    check("rst in_ready",  96'(ir1), 96'd1);
    check("rst stall_cnt", 96'(st1), 96'd0);
    check("rst flush_cnt", 96'(fc1), 96'd0);

    // Streaming with out_ready held high
    drive(1'b1, 1'b0, 1'b1, A, 1'b1);
    check("lat out_valid", 96'(ov1), 96'd1);
    check("lat out_data",  od1, A);
    check("lat occupancy", 96'(oc1), 96'd1);
    check("lat in_ready",  96'(ir1), 96'd1);
    drive(1'b1, 1'b0, 1'b1, A, 1'b1);
    check("stream stall_cnt", 96'(st1), 96'd0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Skid fill and in-order drain
    drive(1'b1, 1'b0, 1'b1, A, 1'b0);
    drive(1'b1, 1'b0, 1'b1, B, 1'b0);
    check("skid occupancy", 96'(oc1), 96'd2);
    check("skid in_ready",  96'(ir1), 96'd0);
    check("noskid in_ready", 96'(ir0), 96'd0);
    check("noskid holds A",  od0, A);
    drive(1'b1, 1'b0, 1'b1, C, 1'b0);
    drive(1'b1, 1'b0, 1'b1, C, 1'b0);
    check("skid stall_cnt", 96'(st1), 96'd3);
    check("skid head A",    od1, A);
    drive(1'b1, 1'b0, 1'b1, C, 1'b1);
    check("drain B", od1, B);
    check("noskid swap C", od0, C);
    check("noskid swap valid", 96'(ov0), 96'd1);
    drive(1'b1, 1'b0, 1'b1, C, 1'b1);
    check("drain C", od1, C);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check("drain empty", 96'(ov1), 96'd0);

    // Flush while two entries held
    drive(1'b1, 1'b0, 1'b1, A, 1'b0);
    drive(1'b1, 1'b0, 1'b1, B, 1'b0);
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = C; out_ready = 1'b0;
    #1;
    check("flush in_ready skid",   96'(ir1), 96'd0);
    check("flush in_ready noskid", 96'(ir0), 96'd0);
    @(posedge clk);
    #1;
    instr_field = od1[31:0];
    check("flush out_valid", 96'(ov1), 96'd0);
    check("flush out_data",  od1, BUB);
    check("flush instr nop", 96'(instr_field), 96'h13);
    check("flush occupancy", 96'(oc1), 96'd0);
    check("flush_cnt skid",  96'(fc1), 96'd1);
    check("flush_cnt noskid", 96'(fc0), 96'd1);
    drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check("flush empty keeps cnt", 96'(fc1), 96'd1);

    // Flush and reset together
    drive(1'b1, 1'b0, 1'b1, A, 1'b1);
    drive(1'b0, 1'b1, 1'b1, B, 1'b1);
    check("rst+flush stall", 96'(st1), 96'd0);
    check("rst+flush fcnt",  96'(fc1), 96'd0);
    check("rst+flush occ",   96'(oc1), 96'd0);
    check("rst+flush valid", 96'(ov1), 96'd0);

    // Stall counter saturation on the 4-bit instance
    drive(1'b1, 1'b0, 1'b1, A, 1'b0);
    repeat (20) drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("sat stall 4b",  96'(st0), 96'd15);
    check("sat stall 16b", 96'(st1), 96'd20);
    check("sat holds A",   od0, A);

    // Randomised traffic
    repeat (800) begin
      drive(($urandom_range(63) != 0), ($urandom_range(15) == 0), ($urandom_range(1) == 1),
            {$urandom, $urandom, $urandom}, ($urandom_range(9) < 6));
    end
    repeat (4) drive(1'b1, 1'b0, 1'b0, '0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register, the successor to the fixed IF/ID register.
- Moves an opaque payload (for example pc/npc/instruction) between two pipeline stages using a valid/ready handshake.
- Optional one-entry skid buffer breaks the combinational ready path.
- Supports synchronous flush with bubble insertion, and provides saturating stall/flush performance counters.
- Instantiated between every pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).

Parameters:
- DATA_W, 96: payload width in bits.
- BUBBLE, {64'd0, `INSTRUCTION_NOP}: payload driven on out_data whenever the stage is empty, reset or flushed.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: width of each performance counter.

Ports:
- clock, input, 1: rising-edge clock (the only clock).
- reset, input, 1: synchronous, active-low reset.
- flush, input, 1: synchronous flush, active-high.
- in_valid, input, 1: upstream stage presents a payload.
- in_ready, output, 1: this stage accepts in_data this cycle.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: out_data holds a real payload.
- out_ready, input, 1: downstream stage consumes out_data this cycle.
- out_data, output, DATA_W: payload to the downstream stage.
- occupancy, output, 2: number of held entries (0..2; at most 1 when SKID=0).
- stall_cnt, output, CNT_W: count of back-pressure cycles.
- flush_cnt, output, CNT_W: count of flushes that discarded a payload.

Behaviour:
- Transfer rules:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - All state updates happen on posedge clock.
- Reset (reset==0), highest priority:
  - Next edge: out_valid=0, out_data=BUBBLE, skid entry empty, occupancy=0, stall_cnt=0, flush_cnt=0.
  - in_ready=1 after reset.
  - Reset asserted mid-transfer discards all held data.
- Flush (reset==1, flush==1), second priority:
  - Same effect on the data path as reset: both entries cleared, out_valid=0, out_data=BUBBLE.
  - Counters are retained.
  - in_ready is forced to 0 during the flush cycle, so no input is accepted.
  - out_valid is not masked combinationally; a downstream consume in the flush cycle still occurs, and the downstream stage is expected to flush too.
- Latency:
  - One cycle from input transfer to out_valid=1 when the stage is empty.
  - No combinational path from in_data to out_data.
- SKID=1, states EMPTY / FULL / SKIDDED:
  - EMPTY: in_ready=1, out_valid=0. On input transfer -> FULL, main register loads in_data.
  - FULL, in_ready=1:
    - input transfer and output transfer together: main register loads in_data, stays FULL.
    - output transfer only -> EMPTY.
    - input transfer only -> SKIDDED, skid register loads in_data.
  - SKIDDED: in_ready=0. On output transfer, main register loads the skid entry -> FULL.
  - in_ready is a registered value: 1 iff the next state is not SKIDDED.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational, and masked by flush).
  - On input transfer, main register loads in_data and out_valid=1.
  - On output transfer without input transfer, out_valid=0.
- out_data:
  - Equals the main register when out_valid=1.
  - Equals BUBBLE when out_valid=0, so downstream stages see a NOP.
- Ordering: payloads leave in strict arrival order; none are dropped or duplicated except by flush or reset.
- stall_cnt: +1 each cycle with out_valid && !out_ready; saturates at all-ones.
- flush_cnt: +1 on each flush cycle with occupancy!=0; saturates at all-ones.
- Counter updates are suppressed when reset==0.

Decomposition:
- `INSTRUCTION_NOP and the default BUBBLE field layout (pc[95:64], npc[63:32], instr[31:0]) live in def.v.
- Add a PIPE_CNT_W default constant to def.v.
- One sub-module, sat_counter (CNT_W-wide saturating incrementer with synchronous active-low clear), instantiated twice.

Test Plan:
- Reset, then in_valid=1, in_data=A, out_ready=1 continuously -> out_valid=1 with out_data=A one cycle later; occupancy=1; in_ready stays 1; stall_cnt=0.
- SKID=1: load A, hold out_ready=0, offer B -> B accepted, occupancy=2, in_ready=0 next cycle; C is held upstream; raise out_ready -> A, B, C emerge in order on consecutive cycles; stall_cnt equals the number of cycles out_ready was low.
- Flush while occupancy=2 -> next cycle out_valid=0, out_data=BUBBLE (instr field equals `INSTRUCTION_NOP), occupancy=0, flush_cnt=1; in_ready=0 during the flush cycle; a flush with occupancy=0 leaves flush_cnt unchanged.
- Flush and reset asserted together while in_valid=1 -> counters cleared, input not accepted, occupancy=0.
- SKID=0: out_ready=0 while full -> in_ready=0 in the same cycle; raise out_ready with in_valid=1 -> simultaneous consume and accept, out_data updates with no bubble.
- CNT_W=4: hold out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt saturates at 15 and stays there.
